// File: rtl/shift_add_mult16.sv
// Sequential 16x16 -> 32-bit unsigned shift-and-add multiplier on valid/ready channels.
// Optional macro MULT_ZERO_BYPASS_EN: zero operands skip the add-and-shift loop.

module Adder1_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [16:0] carry;

    assign carry[0] = cin;

    // Plain ripple chain of full adders; the carry path sets the clock period of the multiplier.
    for (genvar i = 0; i < 16; i++) begin : g_fa
        assign sum[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[16];

endmodule

module shift_add_mult16 #(
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_valid,
    output logic                   start_ready,
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [2*WIDTH-1:0]     product,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   mplr;
    logic [3:0]         cnt;
    logic [WIDTH-1:0]   sum;
    logic               cout;

    // Partial product: add the multiplicand into the upper half when the current multiplier bit is set.
    Adder1_16bit u_adder (
        .a    (acc),
        .b    (mcand & {WIDTH{mplr[0]}}),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    // Handshake flags are registered alongside the state so they never depend on inputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            mcand       <= '0;
            acc         <= '0;
            mplr        <= '0;
            cnt         <= '0;
            product     <= '0;
            start_ready <= 1'b1;
            busy        <= 1'b0;
            res_valid   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid && start_ready) begin
                        mcand       <= a;
                        mplr        <= b;
                        acc         <= '0;
                        cnt         <= '0;
                        start_ready <= 1'b0;
`ifdef MULT_ZERO_BYPASS_EN
                        if ((a == '0) || (b == '0)) begin
                            product   <= '0;
                            res_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            busy  <= 1'b1;
                            state <= CALC;
                        end
`else
                        busy  <= 1'b1;
                        state <= CALC;
`endif
                    end
                end

                CALC: begin
                    // The adder carry becomes the new top bit; the sum LSB shifts into the low half.
                    {acc, mplr} <= {cout, sum, mplr[WIDTH-1:1]};
                    cnt         <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        product   <= {cout, sum, mplr[WIDTH-1:1]};
                        busy      <= 1'b0;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end
                end

                DONE: begin
                    if (res_ready) begin
                        res_valid   <= 1'b0;
                        start_ready <= 1'b1;
                        state       <= IDLE;
                    end
                end

                default: begin
                    start_ready <= 1'b1;
                    busy        <= 1'b0;
                    res_valid   <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_mult16.sv
// Directed self-checking bench for shift_add_mult16; honours MULT_ZERO_BYPASS_EN for zero-operand latency.

module tb_shift_add_mult16;

    logic        clk;
    logic        rst_n;
    logic        start_valid;
    logic        start_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] product;
    logic        busy;

    int testCount;
    int failCount;
    int edges;
    logic [31:0] heldProduct;

    shift_add_mult16 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .product     (product),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #75 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Present operands at a falling edge and hold them across exactly one rising edge.
    task automatic applyStimulus(input logic [15:0] x, input logic [15:0] y);
        a           = x;
        b           = y;
        start_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        a           = 16'($urandom);
        b           = 16'($urandom);
    endtask

    // Count edges from the accept edge (inclusive) until res_valid is seen, bounded.
    task automatic waitResult(output int count);
        count = 1;
        while (!res_valid && count < 40) begin
            @(negedge clk);
            count++;
        end
    endtask

    task automatic consumeResult(input string tag, input logic [31:0] expected);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checkOutput({tag, "_validDrop"}, 32'(res_valid), 32'd0);
        checkOutput({tag, "_readyBack"}, 32'(start_ready), 32'd1);
        checkOutput({tag, "_productHeld"}, product, expected);
    endtask

    task automatic runMultiply(input string tag, input logic [15:0] x, input logic [15:0] y,
                               input logic [31:0] expected, input int expEdges);
        checkOutput({tag, "_startReady"}, 32'(start_ready), 32'd1);
        applyStimulus(x, y);
        waitResult(edges);
        checkOutput({tag, "_latency"}, 32'(edges), 32'(expEdges));
        checkOutput({tag, "_product"}, product, expected);
        checkOutput({tag, "_busyDone"}, 32'(busy), 32'd0);
        consumeResult(tag, expected);
    endtask

    initial begin
        testCount   = 0;
        failCount   = 0;
        rst_n       = 1'b0;
        start_valid = 1'($urandom);
        res_ready   = 1'($urandom);
        a           = 16'($urandom);
        b           = 16'($urandom);

        // Reset held over two edges with random inputs.
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n       = 1'b1;
        start_valid = 1'b0;
        res_ready   = 1'b0;
        checkOutput("reset_startReady", 32'(start_ready), 32'd1);
        checkOutput("reset_resValid", 32'(res_valid), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_product", product, 32'd0);

        // Basic multiply with busy observed right after accept.
        applyStimulus(16'h0003, 16'h0005);
        checkOutput("basic_busyCalc", 32'(busy), 32'd1);
        checkOutput("basic_notReadyCalc", 32'(start_ready), 32'd0);
        waitResult(edges);
        checkOutput("basic_latency", 32'(edges), 32'd17);
        checkOutput("basic_product", product, 32'h0000000F);
        consumeResult("basic", 32'h0000000F);

        runMultiply("mixed", 16'h0137, 16'h03F1, 32'h0004C9C7, 17);
        runMultiply("maxmax", 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 17);
        runMultiply("bigx2", 16'hFDE8, 16'h0002, 32'h0001FBD0, 17);

        // Backpressure: result held while a new request waits.
        applyStimulus(16'h1111, 16'h0003);
        waitResult(edges);
        checkOutput("bp_latency", 32'(edges), 32'd17);
        a           = 16'h0010;
        b           = 16'h0010;
        start_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_productStable", product, 32'h00003333);
            checkOutput("bp_startReadyLow", 32'(start_ready), 32'd0);
            checkOutput("bp_validHeld", 32'(res_valid), 32'd1);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checkOutput("bp_idleNotAccepted", 32'(start_ready), 32'd1);
        checkOutput("bp_idleBusy", 32'(busy), 32'd0);
        @(negedge clk);
        start_valid = 1'b0;
        checkOutput("bp_acceptedBusy", 32'(busy), 32'd1);
        waitResult(edges);
        checkOutput("bp_newLatency", 32'(edges), 32'd17);
        checkOutput("bp_newProduct", product, 32'h00000100);
        consumeResult("bp_new", 32'h00000100);

        // Reset at CALC cycle 8 aborts the operation.
        applyStimulus(16'h1234, 16'h5678);
        repeat (7) @(negedge clk);
        checkOutput("abort_busyBefore", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("abort_startReady", 32'(start_ready), 32'd1);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_resValid", 32'(res_valid), 32'd0);
        checkOutput("abort_product", product, 32'd0);
        runMultiply("afterAbort", 16'h0002, 16'h0004, 32'h00000008, 17);

        // Zero operand: latency depends on the bypass build option.
`ifdef MULT_ZERO_BYPASS_EN
        runMultiply("zeroA", 16'h0000, 16'h1234, 32'h00000000, 1);
`else
        runMultiply("zeroA", 16'h0000, 16'h1234, 32'h00000000, 17);
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/shift_add_mult16.md
# shift_add_mult16

Sequential 16×16 → 32-bit unsigned multiplier built around the team's 16-bit ripple-carry adder (`Adder1_16bit`), which it instantiates as its partial-product adder. The block performs one add-and-shift step per clock, so the combinational adder becomes a registered datapath stage. Operands arrive on a valid/ready request channel, and the product leaves on a valid/ready result channel. It is the first clocked consumer of the adder library and the reference user for timing-closing the gate-delay adders.

## Interface
- `WIDTH`, default 16: operand width. Fixed at 16 because the adder instance is 16 bits wide. Any other value is unsupported.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `start_valid`  in  1  request: `a`/`b` are valid.
- `start_ready`  out  1  block can accept a request. High only in IDLE.
- `a`  in  16  multiplicand, sampled only on the accept edge.
- `b`  in  16  multiplier, sampled only on the accept edge.
- `res_valid`  out  1  `product` is valid. High only in DONE.
- `res_ready`  in  1  consumer takes the result.
- `product`  out  32  unsigned `a*b`. Registered.
- `busy`  out  1  high in CALC.

## Operation
- Registers:
  - `mcand[15:0]`
  - `acc[15:0]` (upper half of the product)
  - `mplr[15:0]` (lower half of the product / remaining multiplier bits)
  - `cnt[3:0]`
  - `state`
  - `product[31:0]`
- Adder instance connections:
  - A = `acc`
  - B = `mcand & {16{mplr[0]}}`
  - Cin = 0
  - outputs {`cout`, `sum`}
- States: IDLE, CALC, DONE. `start_ready`, `busy` and `res_valid` are decoded from `state` only, never from inputs.
- IDLE:
  - Accept when `start_valid && start_ready` at an edge: `mcand<=a`, `mplr<=b`, `acc<=0`, `cnt<=0`, then go to CALC.
  - Without a request, remain in IDLE; `a`/`b` are ignored.
- CALC, each edge:
  - `{acc,mplr} <= {cout, sum, mplr[15:1]}`.
  - `cnt<=cnt+1`.
  - When `cnt==15`, go to DONE and load `product <= {cout, sum, mplr[15:1]}`.
- DONE:
  - Hold `product` and `res_valid=1` until `res_ready` is high at an edge, then go to IDLE.
  - `product` keeps its last value after leaving DONE.
- No new request is accepted in DONE or CALC, including the same cycle the result is consumed. The earliest next accept is the edge after the return to IDLE.
- Arithmetic: unsigned only, no overflow possible. The 32-bit result is exact: 0xFFFF×0xFFFF = 0xFFFE0001.
- `start_valid` dropped or `a`/`b` changed during CALC/DONE: no effect.
- `res_ready` high outside DONE: ignored.

## Timing
- Reset values (after any edge with `rst_n`=0): state=IDLE, `start_ready`=1, `busy`=0, `res_valid`=0, `product`=0. `acc`, `mplr`, `mcand` and `cnt` are all 0.
- Reset while in CALC or DONE aborts the operation immediately. No partial result is presented.
- Latency:
  - Accept edge E0, then CALC occupies edges E1..E16.
  - `res_valid` rises after E16, giving 16 busy cycles and a 17-edge request-to-result latency.
  - `res_ready` held high: DONE lasts exactly one cycle, for a throughput of one product per 18 cycles.
- Clock period must exceed the worst-case propagation of the gate-delay adder plus the AND masking (≥120 time units). Benches use a 150-unit period.

## Configuration
- `MULT_ZERO_BYPASS_EN`
  - Defined: at the accept edge, if `a==0` or `b==0`, skip CALC. Go directly to DONE with `product<=0`, so `res_valid` rises after E0 (latency 1 edge) and `busy` never asserts.
  - Undefined: zero operands take the full 16-cycle CALC path like any other value.
  - Result values are identical in both builds; only latency differs.

## Test plan
- Reset: hold `rst_n`=0 for 2 edges with random inputs, then release. Required: `start_ready`=1, `res_valid`=0, `busy`=0, `product`=0.
- Basic multiply: `a`=0x0003, `b`=0x0005, `res_ready`=1. Required: `product`=0x0000000F with `res_valid` rising exactly 16 cycles after accept. Also `a`=0x0137, `b`=0x03F1 → 0x0004C9C7.
- Extremes: 0xFFFF×0xFFFF → 0xFFFE0001. 0xFDE8×0x0002 → 0x0001FBD0.
- Backpressure: `res_ready`=0 for 5 cycles in DONE while `start_valid` stays high with new operands. Required: `product` stable, `start_ready`=0 throughout, and the new request is accepted only on the edge after the return to IDLE.
- Reset mid-operation: assert `rst_n`=0 at CALC cycle 8. Required: IDLE with `product`=0 on the next edge, and a following 0x0002×0x0004 → 0x00000008 with normal latency.
- Zero operand: 0x0000×0x1234 → `product`=0. Required latency is 1 edge with `MULT_ZERO_BYPASS_EN` defined and 17 edges without it.
